pipe_mem_stage: RTL and testbench

//   MEM stage of the 5-stage pipeline. Consumes the EX/MEM register outputs
//   and runs the data-memory access over a req/ack handshake. Stalls the

---
 rtl/pipe_mem_stage.sv | 134 +++++++++++++
 tb/tb_pipe_mem_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_stage.sv
// MEM stage: drives the data-memory req/ack handshake from the EX/MEM register,
// stalls the front of the pipe while the memory is busy, loads MEM/WB, and
// aborts accesses that are never acknowledged (sticky dm_err).
module pipe_mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mstall,
  output logic        dm_err,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_err;
  logic          w_memop, w_abort, w_take, w_err_set;

  assign w_memop  = mwmem | mm2reg;
  assign dm_req   = w_memop & ~clr;
  assign dm_we    = mwmem;
  assign dm_addr  = malu;
  assign dm_wdata = mb;
  assign dm_err   = r_err;

  // Abort on the last allowed wait cycle unless the ack shows up in it.
  // With MAX_WAIT==1 the first (IDLE) request cycle is already the last one.
  always_comb begin
    w_abort = 1'b0;
    if (w_memop && !dm_ack) begin
      if (r_state == ACCESS)
        w_abort = (r_cnt == CW'(MAX_WAIT - 1));
      else
        w_abort = (MAX_WAIT == 1);
    end
  end

  assign mstall = w_memop & ~dm_ack & ~w_abort;

  // Next-state logic: w_take loads MEM/WB from EX/MEM, otherwise a bubble.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_take     = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_memop || dm_ack) begin
          w_take = 1'b1;
        end else if (w_abort) begin
          w_err_set = 1'b1;
        end else begin
          w_state_nx = ACCESS;
          w_cnt_nx   = CW'(1);
        end
      end
      ACCESS: begin
        // A withdrawn request (EX/MEM no longer holds a memop) is treated
        // as plain pass-through so the FSM cannot get stuck waiting.
        if (!w_memop || dm_ack) begin
          w_take     = 1'b1;
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else if (w_abort) begin
          w_err_set  = 1'b1;
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // State, wait counter and sticky error register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // MEM/WB register: completed/pass-through instruction or a bubble.
  // A store that also has mm2reg set is a store, so it never selects memory data.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wmo    <= '0;
      walu   <= '0;
      wrn    <= '0;
    end else if (w_take) begin
      wwreg  <= mwreg;
      wm2reg <= mm2reg & ~mwmem;
      wmo    <= (mm2reg & ~mwmem) ? dm_rdata : 32'h0;
      walu   <= malu;
      wrn    <= mrn;
    end else begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wmo    <= '0;
      walu   <= '0;
      wrn    <= '0;
    end
  end
endmodule

// File: tb/tb_pipe_mem_stage.sv
// Bench for pipe_mem_stage: directed vectors with literal expectations plus a
// behavioural model checked against the DUT on every falling edge.
module tb_pipe_mem_stage;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        mwreg = 0, mm2reg = 0, mwmem = 0, dm_ack = 0;
  logic [31:0] malu = 0, mb = 0, dm_rdata = 0;
  logic [4:0]  mrn = 0;
  logic        dm_req, dm_we, mstall, dm_err, wwreg, wm2reg;
  logic [31:0] dm_addr, dm_wdata, wmo, walu;
  logic [4:0]  wrn;

  int total = 0;
  int bad   = 0;

  pipe_mem_stage #(.MAX_WAIT(MW)) dut (
    .clk(clk), .clr(clr), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .mrn(mrn), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_ack(dm_ack), .mstall(mstall), .dm_err(dm_err), .wwreg(wwreg),
    .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_waited = number of consecutive request cycles already spent without ack.
  int          m_waited = 0;
  logic        m_err = 0, m_wwreg = 0, m_wm2reg = 0;
  logic [31:0] m_wmo = 0, m_walu = 0;
  logic [4:0]  m_wrn = 0;

  function automatic logic is_load();
    return mm2reg && !mwmem;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_waited = 0; m_err = 0; m_wwreg = 0; m_wm2reg = 0;
      m_wmo = 0; m_walu = 0; m_wrn = 0;
    end else if (!(mwmem || mm2reg) || dm_ack) begin
      m_waited = 0;
      m_wwreg  = mwreg;
      m_wm2reg = is_load();
      m_wmo    = is_load() ? dm_rdata : 32'h0;
      m_walu   = malu;
      m_wrn    = mrn;
    end else begin
      m_wwreg = 0; m_wm2reg = 0; m_wmo = 0; m_walu = 0; m_wrn = 0;
      if (m_waited == MW - 1) begin
        m_err    = 1;
        m_waited = 0;
      end else begin
        m_waited = m_waited + 1;
      end
    end
  end

  // Compare process: every falling edge, DUT vs model.
  always @(negedge clk) begin
    logic memop, last;
    memop = mwmem | mm2reg;
    last  = memop && !dm_ack && (m_waited == MW - 1);
    chk("cmp_req",    dm_req,   memop & ~clr);
    chk("cmp_we",     dm_we,    mwmem);
    chk("cmp_addr",   dm_addr,  malu);
    chk("cmp_wdata",  dm_wdata, mb);
    chk("cmp_stall",  mstall,   memop & ~dm_ack & ~last);
    chk("cmp_err",    dm_err,   m_err);
    chk("cmp_wwreg",  wwreg,    m_wwreg);
    chk("cmp_wm2reg", wm2reg,   m_wm2reg);
    chk("cmp_wmo",    wmo,      m_wmo);
    chk("cmp_walu",   walu,     m_walu);
    chk("cmp_wrn",    {27'b0, wrn}, {27'b0, m_wrn});
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic setin(input logic w, input logic l, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rn, input logic ak,
                       input logic [31:0] rd);
    mwreg = w; mm2reg = l; mwmem = s; malu = a; mb = b; mrn = rn;
    dm_ack = ak; dm_rdata = rd;
  endtask

  initial begin
    int rq, st, ws;
    logic last_st;

    // Reset with a load presented: request must be suppressed.
    setin(1, 1, 0, 32'h44, 0, 3, 0, 0);
    repeat (2) nxt();
    #1;
    chk("rst_req",  dm_req, 0);
    chk("rst_wwreg", wwreg, 0);
    chk("rst_walu", walu, 0);
    chk("rst_err",  dm_err, 0);
    nxt();
    clr = 0;

    // ALU op pass-through.
    setin(1, 0, 0, 32'h0000_1234, 0, 5, 0, 0);
    #1;
    chk("alu_req", dm_req, 0);
    chk("alu_stall", mstall, 0);
    nxt();
    chk("alu_wwreg", wwreg, 1);
    chk("alu_walu", walu, 32'h1234);
    chk("alu_wrn", {27'b0, wrn}, 5);
    chk("alu_wmo", wmo, 0);

    // Zero-wait load.
    setin(1, 1, 0, 32'h40, 0, 12, 1, 32'hDEAD_BEEF);
    #1;
    chk("zw_stall", mstall, 0);
    chk("zw_we", dm_we, 0);
    chk("zw_req", dm_req, 1);
    nxt();
    chk("zw_wmo", wmo, 32'hDEAD_BEEF);
    chk("zw_wm2reg", wm2reg, 1);
    chk("zw_wrn", {27'b0, wrn}, 12);

    // 3-wait store, ack in 4th cycle.
    setin(0, 0, 1, 32'h80, 32'hA5A5_A5A5, 2, 0, 0);
    rq = 0; st = 0; ws = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) dm_ack = 1;
      #1;
      if (dm_req && dm_we) rq++;
      if (mstall) st++;
      if (dm_wdata == 32'hA5A5_A5A5) ws++;
      nxt();
      if (c < 4) chk("st_bubble", {31'b0, wwreg} | walu, 0);
    end
    chk("st_req_cycles", rq, 4);
    chk("st_stall_cycles", st, 3);
    chk("st_wdata_stable", ws, 4);
    chk("st_err", dm_err, 0);
    chk("st_walu", walu, 32'h80);
    chk("st_wm2reg", wm2reg, 0);

    // Reset in the 2nd wait cycle of a load.
    setin(1, 1, 0, 32'hC0, 0, 6, 0, 0);
    nxt();
    #1;
    clr = 1;
    #1;
    chk("rmid_req", dm_req, 0);
    chk("rmid_wwreg", wwreg, 0);
    chk("rmid_err", dm_err, 0);
    nxt();
    clr = 0;
    setin(1, 0, 0, 32'h77, 0, 8, 0, 0);
    #1;
    chk("rmid_stall", mstall, 0);
    nxt();
    chk("rmid_walu", walu, 32'h77);

    // Timeout: load never acknowledged.
    setin(1, 1, 0, 32'h100, 0, 7, 0, 0);
    rq = 0; last_st = 1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (dm_req) rq++;
      if (c == 4) last_st = mstall;
      nxt();
    end
    chk("to_req_cycles", rq, 4);
    chk("to_last_stall", last_st, 0);
    chk("to_err", dm_err, 1);
    chk("to_bubble", {31'b0, wwreg} | walu, 0);
    setin(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("to_idle_stall", mstall, 0);
    nxt();
    chk("to_err_sticky", dm_err, 1);

    // Clear the error, then ack arriving in the final allowed cycle.
    clr = 1;
    nxt();
    clr = 0;
    setin(1, 1, 0, 32'h200, 0, 9, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin dm_ack = 1; dm_rdata = 32'h1234_5678; end
      #1;
      if (c == 4) chk("al_stall", mstall, 0);
      nxt();
    end
    chk("al_err", dm_err, 0);
    chk("al_wmo", wmo, 32'h1234_5678);
    chk("al_wwreg", wwreg, 1);
    setin(1, 0, 0, 32'h55, 0, 4, 0, 0);
    #1;
    chk("al_next_stall", mstall, 0);
    nxt();
    chk("al_next_walu", walu, 32'h55);
    chk("al_next_err", dm_err, 0);

    // Load with mwreg=0 and store with mwreg=1 pass their write enable through.
    setin(0, 1, 0, 32'h300, 0, 10, 1, 32'hCAFE_0001);
    nxt();
    chk("ld_nowreg_wwreg", wwreg, 0);
    chk("ld_nowreg_wmo", wmo, 32'hCAFE_0001);
    setin(1, 1, 1, 32'h304, 32'h99, 11, 1, 32'hFFFF_FFFF);
    #1;
    chk("both_we", dm_we, 1);
    nxt();
    chk("both_wwreg", wwreg, 1);
    chk("both_wm2reg", wm2reg, 0);
    chk("both_wmo", wmo, 0);

    setin(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
